// File: rtl/fir_pkg.sv
// Shared types and helpers for the streaming FIR filter.
//   fir_state_e   : control FSM states (IDLE, MAC, OUT)
//   sat_result_t  : clamped output value plus saturation bit
//   acc_width()   : accumulator width needed for a given tap count
//   sat_unsigned(): rescale an accumulator and clamp it to an unsigned range
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_e;

  typedef struct packed {
    logic        sat;
    logic [31:0] value;
  } sat_result_t;

  function automatic int acc_width(int taps, int data_w, int coef_w);
    return data_w + coef_w + $clog2(taps) + 1;
  endfunction

  // Floor-shift the accumulator down to integer scale, then clamp to
  // [0, 2^data_w-1]; sat is set whenever clamping changed the value.
  function automatic sat_result_t sat_unsigned(logic signed [63:0] acc,
                                               int frac_bits, int data_w);
    logic signed [63:0] shifted;
    logic signed [63:0] max_val;
    sat_result_t        r;
    shifted = acc >>> frac_bits;
    max_val = (64'sd1 <<< data_w) - 64'sd1;
    if (shifted < 64'sd0) begin
      r.sat   = 1'b1;
      r.value = '0;
    end else if (shifted > max_val) begin
      r.sat   = 1'b1;
      r.value = 32'(max_val);
    end else begin
      r.sat   = 1'b0;
      r.value = 32'(shifted);
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_stream_filter_if.sv
// Stream and coefficient bus of the FIR filter.
//   in_valid/in_ready/in_data       : input sample handshake
//   out_valid/out_ready/out_data    : output sample handshake
//   sat_flag                        : output was clamped (qualified by out_valid)
//   coef_we/coef_addr/coef_wdata    : coefficient write port
// master = sample source / controller side, slave = filter side.
interface fir_stream_filter_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int ADDR_W = 6
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     sat_flag;
  logic                     coef_we;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/fir_mac.sv
// Single multiply(-pre-add)-accumulate stage of the FIR filter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (wins over en)
//   en         : add the current product into the accumulator
//   sample_a   : unsigned history sample hist[n-k]
//   sample_b   : unsigned mirrored sample hist[n-(TAPS-1-k)] (FIR_SYMMETRIC_EN only)
//   pre_add    : add sample_b before the multiply (FIR_SYMMETRIC_EN only)
//   coef       : signed coefficient for this tap
//   acc        : registered accumulator
//   acc_nxt    : accumulator including the current product (combinational)
// Build option: FIR_SYMMETRIC_EN enables the pre-adder.
module fir_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 27
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [DATA_W-1:0]        sample_a,
`ifdef FIR_SYMMETRIC_EN
  input  logic [DATA_W-1:0]        sample_b,
  input  logic                     pre_add,
`endif
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  acc_nxt
);

`ifdef FIR_SYMMETRIC_EN
  localparam int OP_W = DATA_W + 2;
  logic signed [OP_W-1:0] operand;
  // Centre tap of an odd-length filter has no mirror partner.
  assign operand = pre_add ? ($signed({2'b00, sample_a}) + $signed({2'b00, sample_b}))
                           : $signed({2'b00, sample_a});
`else
  localparam int OP_W = DATA_W + 1;
  logic signed [OP_W-1:0] operand;
  assign operand = $signed({1'b0, sample_a});
`endif

  logic signed [OP_W+COEF_W-1:0] prod;

  assign prod    = (OP_W+COEF_W)'(operand) * (OP_W+COEF_W)'(coef);
  assign acc_nxt = acc + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_nxt;
    end
  end

endmodule

// File: rtl/fir_stream_filter.sv
// Streaming FIR low-pass filter with a time-multiplexed MAC (one tap/cycle).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fir_stream_filter_if (sample in/out handshakes,
//                sat_flag, coefficient write port)
//   flush      : synchronous clear of history and in-flight work (coefs kept)
//   busy       : high in MAC or OUT
// Build option: FIR_SYMMETRIC_EN folds symmetric taps through a pre-adder,
// halving the MAC cycles; only the first ceil(TAPS/2) coefs are writable.
module fir_stream_filter
  import fir_pkg::*;
#(
  parameter int TAPS      = 50,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 14,
  parameter int ACC_W     = acc_width(TAPS, DATA_W, COEF_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  fir_stream_filter_if.slave  bus,
  input  logic                flush,
  output logic                busy
);

  localparam int AW = $clog2(TAPS);
`ifdef FIR_SYMMETRIC_EN
  localparam int MAC_N  = (TAPS + 1) / 2;
`else
  localparam int MAC_N  = TAPS;
`endif
  localparam int COEF_N = MAC_N;

  fir_state_e               state, state_nxt;
  logic [DATA_W-1:0]        hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic [AW-1:0]            wr_ptr, k;
  logic [AW-1:0]            idx_a;
  logic [AW:0]              raw_a;
  logic                     accept, mac_last, mac_clr, mac_en;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  sat_result_t              sat_r;

  assign bus.in_ready  = (state == IDLE) && !flush;
  assign bus.out_valid = (state == OUT);
  assign busy          = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign mac_last      = (state == MAC) && (k == AW'(MAC_N - 1));

  // Newest sample sits at wr_ptr; tap k reaches k samples back, modulo TAPS.
  assign raw_a = {1'b0, wr_ptr} + (AW+1)'(TAPS) - {1'b0, k};
  assign idx_a = (raw_a >= (AW+1)'(TAPS)) ? AW'(raw_a - (AW+1)'(TAPS)) : AW'(raw_a);

`ifdef FIR_SYMMETRIC_EN
  logic [AW:0]   raw_b;
  logic [AW-1:0] idx_b;
  logic          pre_add;
  // Mirror tap TAPS-1-k is (wr_ptr + k + 1) mod TAPS.
  assign raw_b   = {1'b0, wr_ptr} + {1'b0, k} + (AW+1)'(1);
  assign idx_b   = (raw_b >= (AW+1)'(TAPS)) ? AW'(raw_b - (AW+1)'(TAPS)) : AW'(raw_b);
  assign pre_add = ({1'b0, k} << 1) != (AW+1)'(TAPS - 1);
`endif

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (mac_clr),
    .en       (mac_en),
    .sample_a (hist[idx_a]),
`ifdef FIR_SYMMETRIC_EN
    .sample_b (hist[idx_b]),
    .pre_add  (pre_add),
`endif
    .coef     (coef[k]),
    .acc      (acc),
    .acc_nxt  (acc_nxt)
  );

  assign sat_r = sat_unsigned(64'(acc_nxt), FRAC_BITS, DATA_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      mac_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state_nxt = MAC;
          mac_clr   = 1'b1;
        end
        MAC: begin
          mac_en = 1'b1;
          if (mac_last) state_nxt = OUT;
        end
        OUT: if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      k            <= '0;
      bus.out_data <= '0;
      bus.sat_flag <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
    end else begin
      // A write landing with an accepted sample is already visible at tap 0.
      if (state == IDLE && bus.coef_we && int'(bus.coef_addr) < COEF_N) begin
        coef[bus.coef_addr] <= bus.coef_wdata;
      end
      if (flush) begin
        wr_ptr <= '0;
        k      <= '0;
        for (int i = 0; i < TAPS; i++) begin
          hist[i] <= '0;
        end
      end else if (accept) begin
        hist[wr_ptr] <= bus.in_data;
        k            <= '0;
      end else if (state == MAC) begin
        k <= k + AW'(1);
        if (mac_last) begin
          bus.out_data <= DATA_W'(sat_r.value);
          bus.sat_flag <= sat_r.sat;
          wr_ptr       <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_filter.sv
// Directed bench for fir_stream_filter at TAPS=4, DATA_W=8, COEF_W=16, Q2.14.
module tb_fir_stream_filter;
  localparam int TAPS      = 4;
  localparam int DATA_W    = 8;
  localparam int COEF_W    = 16;
  localparam int FRAC_BITS = 14;
  localparam int AW        = $clog2(TAPS);

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;
  int   tests;
  int   fails;

  fir_stream_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ADDR_W(AW)) bus ();

  fir_stream_filter #(
    .TAPS      (TAPS),
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .FRAC_BITS (FRAC_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .flush (flush),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = AW'(addr);
    bus.coef_wdata = COEF_W'(val);
    @(negedge clk);
    bus.coef_we    = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
  endtask

  // Push one sample, wait (bounded) for out_valid, capture, then handshake.
  // lat counts falling edges after the accepting edge (first one = 1).
  task automatic run_sample(input int d, output logic [DATA_W-1:0] data,
                            output logic sat, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    data = bus.out_data;
    sat  = bus.sat_flag;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic stable;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    #12;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
        bus.sat_flag !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%0d sat=%b busy=%b, required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.sat_flag, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 ||
          bus.sat_flag !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_stable: outputs changed during idle cycles, actual stable=%b required 1", stable);
    end
  endtask

  task automatic test_impulse();
    int                ins  [4] = '{200, 0, 0, 0};
    int                exps [4] = '{200, 100, 50, 0};
    logic [DATA_W-1:0] d;
    logic              s;
    int                lat;
    set_coefs(16384, 8192, 4096, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(ins[i], d, s, lat);
      tests++;
      if (d !== DATA_W'(exps[i])) begin
        fails++;
        $display("FAIL impulse_data[%0d]: actual %0d required %0d", i, d, exps[i]);
      end
      tests++;
      if (s !== 1'b0) begin
        fails++;
        $display("FAIL impulse_sat[%0d]: actual %b required 0", i, s);
      end
      if (i == 0) begin
        tests++;
        if (lat != TAPS + 1) begin
          fails++;
          $display("FAIL impulse_latency: actual %0d required %0d", lat, TAPS + 1);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [DATA_W-1:0] d;
    logic              s;
    int                lat;
    set_coefs(16384, 16384, 16384, 16384);
    run_sample(255, d, s, lat);
    tests++;
    if (d !== 8'd255 || s !== 1'b0) begin
      fails++;
      $display("FAIL sat_first: actual data=%0d sat=%b required 255 0", d, s);
    end
    run_sample(255, d, s, lat);
    tests++;
    if (d !== 8'd255 || s !== 1'b1) begin
      fails++;
      $display("FAIL sat_clamp_high: actual data=%0d sat=%b required 255 1", d, s);
    end
  endtask

  task automatic test_negative();
    logic [DATA_W-1:0] d;
    logic              s;
    int                lat;
    set_coefs(-16384, 0, 0, 0);
    run_sample(100, d, s, lat);
    tests++;
    if (d !== 8'd0 || s !== 1'b1) begin
      fails++;
      $display("FAIL sat_clamp_low: actual data=%0d sat=%b required 0 1", d, s);
    end
  endtask

  task automatic test_backpressure();
    logic hold_ok;
    int   cnt;
    write_coef(0, 16384);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_out_valid_timeout: actual out_valid=%b required 1", bus.out_valid);
    end
    // Pending sample plus a coefficient write that must be ignored in OUT.
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'd33;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = '0;
    bus.coef_wdata = 16'sd8192;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd77 || bus.in_ready !== 1'b0 ||
          busy !== 1'b1) hold_ok = 1'b0;
    end
    bus.coef_we = 1'b0;
    tests++;
    if (hold_ok !== 1'b1) begin
      fails++;
      $display("FAIL bp_hold: output not held or input not blocked, actual ok=%b required 1", hold_ok);
    end
    tests++;
    if (bus.out_data !== 8'd77) begin
      fails++;
      $display("FAIL bp_data: actual %0d required 77", bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_after_handshake: actual out_valid=%b in_ready=%b required 0 1",
               bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL bp_pending_accept: actual busy=%b required 1", busy);
    end
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    tests++;
    if (bus.out_data !== 8'd33 || bus.sat_flag !== 1'b0) begin
      fails++;
      $display("FAIL bp_coef_ignored: actual data=%0d sat=%b required 33 0", bus.out_data, bus.sat_flag);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic              seen;
    logic [DATA_W-1:0] d;
    logic              s;
    int                lat;
    set_coefs(16384, 8192, 4096, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL flush_accept: actual busy=%b required 1", busy);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_to_idle: actual busy=%b out_valid=%b required 0 0", busy, bus.out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_discard: actual out_valid_seen=%b required 0", seen);
    end
    @(negedge clk);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd111;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_in_ready: actual %b required 0", bus.in_ready);
    end
    @(negedge clk);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_accept: actual busy=%b required 0", busy);
    end
    run_sample(200, d, s, lat);
    tests++;
    if (d !== 8'd200 || s !== 1'b0) begin
      fails++;
      $display("FAIL flush_history_zero: actual data=%0d sat=%b required 200 0", d, s);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    logic              s;
    int                lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd50;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'd0) begin
      fails++;
      $display("FAIL midreset_state: actual busy=%b out_valid=%b in_ready=%b out_data=%0d required 0 0 1 0",
               busy, bus.out_valid, bus.in_ready, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(50, d, s, lat);
    tests++;
    if (d !== 8'd0 || s !== 1'b0) begin
      fails++;
      $display("FAIL midreset_coefs_cleared: actual data=%0d sat=%b required 0 0", d, s);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_impulse();
    test_saturation();
    test_negative();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_stream_filter.md
Name: fir_stream_filter

Overview:
- Streaming, parametrised FIR low-pass filter and the successor to the frame-based filter.
- Accepts one sample at a time over a valid/ready handshake, keeps a circular history of TAPS samples, and computes each output with one time-multiplexed multiply-accumulate (one tap per cycle).
- Coefficients are runtime-loadable. Output is a saturated unsigned sample, also on valid/ready.
- Sits between the sample source and the output frame buffer in the filter datapath.

Parameters:
- TAPS, 50: number of filter taps (≥2).
- DATA_W, 8: unsigned sample width, in and out.
- COEF_W, 16: signed coefficient width.
- FRAC_BITS, 14: coefficient fractional bits (Q2.14 at defaults).
- ACC_W, DATA_W+COEF_W+$clog2(TAPS)+1: signed accumulator width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  filter can accept a sample.
- in_data  in  DATA_W  unsigned input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  DATA_W  saturated unsigned output.
- sat_flag  out  1  out_data was clamped; qualified by out_valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index.
- coef_wdata  in  COEF_W  signed coefficient value.
- flush  in  1  synchronous clear of history and in-flight work.
- busy  out  1  high in MAC or OUT state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; out_valid=0, out_data=0, sat_flag=0, busy=0, in_ready=1.
  - History cleared to 0; write pointer wr_ptr=0; all coefficients 0.
- FSM states IDLE, MAC, OUT:
  - IDLE: in_ready=1. On in_valid&&in_ready, write in_data to hist[wr_ptr], clear acc, set k=0, go to MAC.
  - MAC: each cycle acc += hist[(wr_ptr-k) mod TAPS] * coef[k]; k increments. After k=TAPS-1, register the result, advance wr_ptr (TAPS-1 wraps to 0), go to OUT.
  - OUT: out_valid=1. out_data and sat_flag are held stable until out_ready. On out_valid&&out_ready go to IDLE; out_valid drops on the next cycle.
- Latency: the accepting edge is cycle 0; out_valid rises at cycle TAPS+1.
- Throughput: minimum TAPS+2 cycles per sample with out_ready held high.
- Backpressure: while in OUT, in_ready=0. Input is never accepted while busy.
- Arithmetic:
  - The sample is zero-extended to a DATA_W+1 signed value; the product is signed; acc is signed ACC_W with no overflow at defaults.
  - result = acc >>> FRAC_BITS (arithmetic shift, floor).
  - result<0 gives 0; result>2^DATA_W-1 gives 2^DATA_W-1. sat_flag=1 in either case, else 0.
- Start-up: history reads before TAPS samples have been accepted return 0 (zero-padded start).
- Coefficient writes:
  - Accepted only in IDLE; coef_we in MAC or OUT is ignored.
  - coef_addr ≥ TAPS is ignored.
  - A write and an accepted sample in the same IDLE cycle: the new coefficient is used for that sample.
- flush (highest priority after reset, any state):
  - Next cycle: IDLE, history zeroed, wr_ptr=0, out_valid=0, and any in-flight result is discarded.
  - in_ready=0 during the flush cycle, so no sample is accepted.
  - Coefficients are kept.
- Reset asserted mid-operation is identical to power-up reset; the in-flight sample is lost.

Optional Feature:
- FIR_SYMMETRIC_EN defined:
  - Coefficients are treated as symmetric. Only addresses < ceil(TAPS/2) are writable; higher addresses are ignored.
  - MAC pre-adds hist[n-k]+hist[n-(TAPS-1-k)] before the multiply, over ceil(TAPS/2) cycles. For odd TAPS the centre tap is not pre-added.
  - Latency becomes ceil(TAPS/2)+1.
  - The pre-add operand is DATA_W+2 bits signed.
- Not defined: full TAPS-cycle MAC as above, with all TAPS coefficients independently writable.

Decomposition:
- Package fir_pkg:
  - state enum fir_state_e {IDLE, MAC, OUT}.
  - function acc_width(taps, data_w, coef_w).
  - function sat_unsigned(acc, frac_bits, data_w), returning the clamped value and the sat bit.
- Sub-module fir_mac: one multiply(-pre-add)-accumulate stage with clear and enable inputs.
- FSM, history buffer and coefficient register file stay in fir_stream_filter.

Test Plan:
1. Reset release -> in_ready=1, out_valid=0, out_data=0, busy=0; all outputs stable for 10 idle cycles.
2. TAPS=4, coef {16384,8192,4096,0}, inputs 200,0,0,0 -> outputs 200,100,50,0; first out_valid exactly 5 cycles after accept; sat_flag=0 on all.
3. TAPS=4, all coef 16384, inputs 255,255 -> outputs 255 (sat_flag=0), then 255 (510 clamped, sat_flag=1).
4. coef[0]=-16384, others 0, input 100 -> out_data=0, sat_flag=1.
5. out_ready held low 10 cycles in OUT -> out_valid=1 and out_data constant, in_ready=0; a pending in_valid is accepted only after the handshake; a coef_we during OUT has no effect on the next result.
6. flush on the 2nd MAC cycle -> no out_valid for that sample; then impulse coefs from test 2 with input 200 -> output 200 (history zeroed).
